// File: rtl/n8_pkg.sv
// Shared constants, state type and helpers for the N8 controller-side responder.
package n8_pkg;

    localparam int NUM_BUTTONS = 8;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    localparam logic [3:0] FRAME_BITS = 4'd8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } n8_resp_state_t;

    // Bit counter that sticks at a full frame so extra pulses cannot wrap it.
    function automatic logic [3:0] sat_inc(input logic [3:0] c);
        return (c >= FRAME_BITS) ? FRAME_BITS : c + 4'd1;
    endfunction

endpackage

// File: rtl/n8_controller_responder_if.sv
// Pad-side link bundle: host strobes and button state in, serial data and debug status out.
interface n8_controller_responder_if;
    import n8_pkg::*;

    logic                   latch;
    logic                   pulse;
    logic [NUM_BUTTONS-1:0] buttons;
    logic                   clear_err;
    logic                   data_out;
    logic                   frame_strobe;
    logic [15:0]            frame_count;
    logic                   overrun;
    logic                   underrun;

    modport master (
        output latch, pulse, buttons, clear_err,
        input  data_out, frame_strobe, frame_count, overrun, underrun
    );

    modport slave (
        input  latch, pulse, buttons, clear_err,
        output data_out, frame_strobe, frame_count, overrun, underrun
    );

endinterface

// File: rtl/n8_input_filter.sv
// Synchronizer plus consecutive-sample glitch filter with one-cycle rise/fall pulses.
module n8_input_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER      = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic x_async,
    output logic x_f,
    output logic x_rise,
    output logic x_fall
);

    localparam int CW = (FILTER > 1) ? $clog2(FILTER) : 1;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   x_f_q, x_f_d;
    logic                   x_prev_q, x_prev_d;
    logic                   sample;

    // The filtered level only flips after FILTER back-to-back samples disagree with it.
    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], x_async};
        sample   = sync_q[SYNC_STAGES-1];
        cnt_d    = '0;
        x_f_d    = x_f_q;
        x_prev_d = x_f_q;
        if (sample != x_f_q) begin
            if (cnt_q == CW'(FILTER - 1)) begin
                x_f_d = sample;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            x_f_q    <= 1'b0;
            x_prev_q <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            x_f_q    <= x_f_d;
            x_prev_q <= x_prev_d;
        end
    end

    assign x_f    = x_f_q;
    assign x_rise = x_f_q & ~x_prev_q;
    assign x_fall = ~x_f_q & x_prev_q;

endmodule

// File: rtl/n8_controller_responder.sv
// Controller end of the N8 pad link: parallel-load / serial-shift emulation with
// frame counting and sticky protocol-error flags.
module n8_controller_responder
    import n8_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER      = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    n8_controller_responder_if.slave  bus
);

    logic latch_f, latch_rise, latch_fall;
    logic pulse_f, pulse_rise, pulse_fall;
    logic filt_unused;

    n8_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER(FILTER)) u_latch_filter (
        .clk     (clk),
        .reset   (reset),
        .x_async (bus.latch),
        .x_f     (latch_f),
        .x_rise  (latch_rise),
        .x_fall  (latch_fall)
    );

    n8_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER(FILTER)) u_pulse_filter (
        .clk     (clk),
        .reset   (reset),
        .x_async (bus.pulse),
        .x_f     (pulse_f),
        .x_rise  (pulse_rise),
        .x_fall  (pulse_fall)
    );

    assign filt_unused = ^{latch_f, pulse_f, pulse_fall};

    n8_resp_state_t         state_q, state_d;
    logic [NUM_BUTTONS-1:0] sr_q, sr_d;
    logic [3:0]             count_q, count_d;
    logic                   frame_strobe_q, frame_strobe_d;
    logic [15:0]            frame_count_q, frame_count_d;
    logic                   overrun_q, overrun_d;
    logic                   underrun_q, underrun_d;

    // A latch rise outranks everything else (including a coincident pulse), and
    // error sets are evaluated after clear_err so a new error always survives.
    always_comb begin
        state_d        = state_q;
        sr_d           = sr_q;
        count_d        = count_q;
        frame_strobe_d = 1'b0;
        frame_count_d  = frame_count_q;
        overrun_d      = overrun_q;
        underrun_d     = underrun_q;

        if (bus.clear_err) begin
            overrun_d  = 1'b0;
            underrun_d = 1'b0;
        end

        if (latch_rise && state_q != LOAD) begin
            if (state_q == SHIFT && count_q != 4'd0) begin
                underrun_d = 1'b1;
            end
            state_d = LOAD;
            sr_d    = ~bus.buttons;
            count_d = 4'd0;
        end else begin
            unique case (state_q)
                IDLE: ;
                LOAD: begin
                    sr_d    = ~bus.buttons;
                    count_d = 4'd0;
                    if (latch_fall) begin
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    if (pulse_rise) begin
                        sr_d    = {1'b1, sr_q[NUM_BUTTONS-1:1]};
                        count_d = sat_inc(count_q);
                        if (count_q == FRAME_BITS - 4'd1) begin
                            state_d        = DONE;
                            frame_strobe_d = 1'b1;
                            frame_count_d  = frame_count_q + 16'd1;
                        end
                    end
                end
                DONE: begin
                    if (pulse_rise) begin
                        sr_d      = {1'b1, sr_q[NUM_BUTTONS-1:1]};
                        count_d   = sat_inc(count_q);
                        overrun_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            sr_q           <= 8'hFF;
            count_q        <= 4'd0;
            frame_strobe_q <= 1'b0;
            frame_count_q  <= 16'd0;
            overrun_q      <= 1'b0;
            underrun_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            sr_q           <= sr_d;
            count_q        <= count_d;
            frame_strobe_q <= frame_strobe_d;
            frame_count_q  <= frame_count_d;
            overrun_q      <= overrun_d;
            underrun_q     <= underrun_d;
        end
    end

    assign bus.data_out     = sr_q[BTN_A];
    assign bus.frame_strobe = frame_strobe_q;
    assign bus.frame_count  = frame_count_q;
    assign bus.overrun      = overrun_q;
    assign bus.underrun     = underrun_q;

endmodule

// File: tb/tb_n8_controller_responder.sv
// Randomized self-checking bench for n8_controller_responder against a frame-level pad model.
module tb_n8_controller_responder;
    import n8_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    n8_controller_responder_if bus ();

    n8_controller_responder #(.SYNC_STAGES(2), .FILTER(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Pad model: a latch snapshots the active-low buttons, each pulse consumes one bit.
    bit         m_open;
    int         m_shifts;
    logic [7:0] m_snap;
    int         m_frames;
    bit         m_over;
    bit         m_under;

    function automatic void model_reset();
        m_open = 0; m_shifts = 0; m_snap = 8'hFF; m_frames = 0; m_over = 0; m_under = 0;
    endfunction

    function automatic void model_latch(input logic [7:0] btn);
        if (m_open && m_shifts >= 1 && m_shifts <= 7) m_under = 1;
        m_open = 1; m_shifts = 0; m_snap = ~btn;
    endfunction

    function automatic void model_pulse();
        if (m_open) begin
            if (m_shifts < 8) begin
                m_shifts++;
                if (m_shifts == 8) m_frames++;
            end else begin
                m_over = 1;
            end
        end
    endfunction

    function automatic logic model_data();
        return (m_open && m_shifts < 8) ? m_snap[m_shifts] : 1'b1;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_latch();
        bus.latch = 1'b1; tick(12);
        bus.latch = 1'b0; tick(12);
        model_latch(bus.buttons);
    endtask

    // 10 cycles high, 10 low; reports where within the pulse frame_strobe was seen.
    task automatic send_pulse(output int strobe_at, output int strobes);
        strobe_at = -1; strobes = 0;
        bus.pulse = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.frame_strobe === 1'b1) begin
                strobes++;
                if (strobe_at < 0) strobe_at = i;
            end
            if (i == 10) bus.pulse = 1'b0;
        end
        model_pulse();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.latch = 1'b0; bus.pulse = 1'b0; bus.buttons = 8'h00; bus.clear_err = 1'b0;
        tick(3);
        reset = 1'b0;
        model_reset();
        tick(1);
        checks++; if (bus.data_out !== 1'b1) begin errors++; $display("[TB] FAIL reset_data_out: got %b expected 1", bus.data_out); end
        checks++; if (bus.frame_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_frame_count: got %0d expected 0", bus.frame_count); end
        checks++; if (bus.overrun !== 1'b0 || bus.underrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags: got %b%b expected 00", bus.overrun, bus.underrun); end
        checks++; if (bus.frame_strobe !== 1'b0) begin errors++; $display("[TB] FAIL reset_strobe: got %b expected 0", bus.frame_strobe); end
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("[TB] FAIL reset_state: got %0d expected IDLE", dut.state_q); end
    endtask

    task automatic test_frame(input logic [7:0] btn, input string tag);
        int sa, ns;
        bus.buttons = btn;
        bus.latch = 1'b1; tick(12);
        checks++; if (bus.data_out !== ~btn[0]) begin errors++; $display("[TB] FAIL %s_load_A: got %b expected %b", tag, bus.data_out, ~btn[0]); end
        bus.latch = 1'b0; tick(12);
        model_latch(btn);
        for (int k = 0; k < 8; k++) begin
            checks++; if (bus.data_out !== model_data()) begin errors++; $display("[TB] FAIL %s_bit%0d: got %b expected %b", tag, k, bus.data_out, model_data()); end
            send_pulse(sa, ns);
            if (k < 7) begin
                checks++; if (ns !== 0) begin errors++; $display("[TB] FAIL %s_early_strobe%0d: got %0d strobes expected 0", tag, k, ns); end
            end else begin
                checks++; if (ns !== 1 || sa !== 5) begin errors++; $display("[TB] FAIL %s_strobe: got %0d strobes at cycle %0d expected 1 at cycle 5", tag, ns, sa); end
            end
        end
        checks++; if (bus.frame_count !== 16'(m_frames)) begin errors++; $display("[TB] FAIL %s_frame_count: got %0d expected %0d", tag, bus.frame_count, m_frames); end
        checks++; if (bus.data_out !== 1'b1) begin errors++; $display("[TB] FAIL %s_done_data: got %b expected 1", tag, bus.data_out); end
    endtask

    task automatic test_random_frames();
        for (int n = 0; n < 4; n++) test_frame(8'($urandom), "rand");
    endtask

    task automatic test_overrun();
        int sa, ns;
        send_pulse(sa, ns);
        checks++; if (bus.overrun !== m_over) begin errors++; $display("[TB] FAIL overrun_set: got %b expected %b", bus.overrun, m_over); end
        checks++; if (bus.data_out !== 1'b1 || ns !== 0) begin errors++; $display("[TB] FAIL overrun_data: got data %b strobes %0d expected 1 and 0", bus.data_out, ns); end
        checks++; if (bus.frame_count !== 16'(m_frames)) begin errors++; $display("[TB] FAIL overrun_count: got %0d expected %0d", bus.frame_count, m_frames); end
        bus.clear_err = 1'b1; tick(1);
        m_over = 0; m_under = 0;
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("[TB] FAIL overrun_clear: got %b expected 0", bus.overrun); end
        bus.clear_err = 1'b0;
        // clear_err lands on the very edge where the overrun is recorded.
        bus.pulse = 1'b1; tick(4);
        bus.clear_err = 1'b1; tick(1);
        bus.clear_err = 1'b0; tick(5);
        bus.pulse = 1'b0; tick(10);
        model_pulse();
        checks++; if (bus.overrun !== m_over) begin errors++; $display("[TB] FAIL overrun_set_wins: got %b expected %b", bus.overrun, m_over); end
        bus.clear_err = 1'b1; tick(1); bus.clear_err = 1'b0;
        m_over = 0; m_under = 0;
    endtask

    task automatic test_underrun();
        int sa, ns;
        bus.buttons = 8'($urandom);
        send_latch();
        for (int k = 0; k < 3; k++) send_pulse(sa, ns);
        bus.buttons = 8'($urandom);
        send_latch();
        checks++; if (bus.underrun !== m_under) begin errors++; $display("[TB] FAIL underrun_set: got %b expected %b", bus.underrun, m_under); end
        checks++; if (bus.frame_count !== 16'(m_frames)) begin errors++; $display("[TB] FAIL underrun_count: got %0d expected %0d", bus.frame_count, m_frames); end
        for (int k = 0; k < 8; k++) begin
            checks++; if (bus.data_out !== model_data()) begin errors++; $display("[TB] FAIL underrun_bit%0d: got %b expected %b", k, bus.data_out, model_data()); end
            send_pulse(sa, ns);
        end
        checks++; if (bus.frame_count !== 16'(m_frames) || ns !== 1) begin errors++; $display("[TB] FAIL underrun_recover: got count %0d strobes %0d expected %0d and 1", bus.frame_count, ns, m_frames); end
        bus.clear_err = 1'b1; tick(1); bus.clear_err = 1'b0;
        m_over = 0; m_under = 0;
        checks++; if (bus.underrun !== 1'b0) begin errors++; $display("[TB] FAIL underrun_clear: got %b expected 0", bus.underrun); end
    endtask

    task automatic test_glitch();
        int sa, ns;
        bus.buttons = 8'($urandom);
        send_latch();
        for (int k = 0; k < 2; k++) send_pulse(sa, ns);
        bus.pulse = 1'b1; tick(1);
        bus.pulse = 1'b0; tick(12);
        checks++; if (bus.data_out !== model_data()) begin errors++; $display("[TB] FAIL glitch_data: got %b expected %b", bus.data_out, model_data()); end
        for (int k = 2; k < 8; k++) begin
            checks++; if (bus.data_out !== model_data()) begin errors++; $display("[TB] FAIL glitch_bit%0d: got %b expected %b", k, bus.data_out, model_data()); end
            send_pulse(sa, ns);
        end
        checks++; if (ns !== 1 || bus.frame_count !== 16'(m_frames)) begin errors++; $display("[TB] FAIL glitch_frame: got strobes %0d count %0d expected 1 and %0d", ns, bus.frame_count, m_frames); end
    endtask

    task automatic test_latch_pulse_same();
        bus.buttons = 8'($urandom);
        bus.latch = 1'b1; bus.pulse = 1'b1; tick(12);
        checks++; if (bus.overrun !== m_over) begin errors++; $display("[TB] FAIL same_edge_overrun: got %b expected %b", bus.overrun, m_over); end
        checks++; if (dut.state_q !== LOAD) begin errors++; $display("[TB] FAIL same_edge_state: got %0d expected LOAD", dut.state_q); end
        checks++; if (bus.data_out !== ~bus.buttons[0]) begin errors++; $display("[TB] FAIL same_edge_data: got %b expected %b", bus.data_out, ~bus.buttons[0]); end
        bus.latch = 1'b0; bus.pulse = 1'b0; tick(12);
        model_latch(bus.buttons);
        checks++; if (bus.data_out !== model_data()) begin errors++; $display("[TB] FAIL same_edge_first_bit: got %b expected %b", bus.data_out, model_data()); end
    endtask

    task automatic test_load_tracking();
        int sa, ns;
        logic [7:0] snap;
        bus.latch = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.buttons = 8'($urandom);
            tick(8);
            checks++; if (bus.data_out !== ~bus.buttons[0]) begin errors++; $display("[TB] FAIL load_track%0d: got %b expected %b", i, bus.data_out, ~bus.buttons[0]); end
        end
        bus.latch = 1'b0; tick(12);
        snap = bus.buttons;
        model_latch(snap);
        bus.buttons = ~snap;
        tick(8);
        for (int k = 0; k < 8; k++) begin
            checks++; if (bus.data_out !== model_data()) begin errors++; $display("[TB] FAIL load_frozen_bit%0d: got %b expected %b", k, bus.data_out, model_data()); end
            send_pulse(sa, ns);
        end
        checks++; if (bus.frame_count !== 16'(m_frames)) begin errors++; $display("[TB] FAIL load_frame_count: got %0d expected %0d", bus.frame_count, m_frames); end
    endtask

    task automatic test_reset_mid_frame();
        int sa, ns;
        bus.buttons = 8'($urandom);
        send_latch();
        for (int k = 0; k < 3; k++) send_pulse(sa, ns);
        reset = 1'b1; tick(2);
        reset = 1'b0;
        model_reset();
        tick(1);
        checks++; if (bus.data_out !== 1'b1 || bus.frame_count !== 16'd0) begin errors++; $display("[TB] FAIL midreset_outputs: got data %b count %0d expected 1 and 0", bus.data_out, bus.frame_count); end
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("[TB] FAIL midreset_state: got %0d expected IDLE", dut.state_q); end
        send_pulse(sa, ns);
        checks++; if (bus.data_out !== model_data() || bus.overrun !== m_over || ns !== 0) begin errors++; $display("[TB] FAIL idle_pulse: got data %b overrun %b strobes %0d expected %b %b 0", bus.data_out, bus.overrun, ns, model_data(), m_over); end
    endtask

    initial begin
        test_reset();
        test_frame(8'b0000_0101, "base");
        test_overrun();
        test_underrun();
        test_random_frames();
        test_glitch();
        test_latch_pulse_same();
        test_load_tracking();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end

endmodule

// File: doc/n8_controller_responder.md
Name: n8_controller_responder

Overview:
- Controller-side end of the N8/NES serial pad link: answers the `latch`/`pulse` strobes from the host driver with 8 serial button bits on `data_out`.
- Emulates the pad's parallel-load / serial-shift register, so the PacMan game can be driven from a second board, a scripted stimulus source or a bench without a physical pad.
- Sits behind V_GPIO pins, wired to the opposite pins from the host driver.
- Adds frame counting and protocol-error flags for link debug.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on the asynchronous `latch`/`pulse` inputs; minimum 2.
- FILTER, 2, number of consecutive identical synchronized samples needed before a `latch`/`pulse` level change is accepted; 1 disables filtering.

Ports:
- clk  input  1  system clock (CLOCK_50 at top level).
- reset  input  1  synchronous, active-high reset.
- latch  input  1  asynchronous latch strobe from the host; high means parallel-load.
- pulse  input  1  asynchronous shift clock from the host; shift on rising edge.
- buttons  input  8  active-high pressed state. Bit order: [0]=A, [1]=B, [2]=select, [3]=start, [4]=up, [5]=down, [6]=left, [7]=right.
- clear_err  input  1  one-cycle request to clear `overrun` and `underrun`.
- data_out  output  1  serial data, active-low (0 = pressed); equals `sr[0]`.
- frame_strobe  output  1  one-cycle pulse when the 8th bit has been shifted out.
- frame_count  output  16  completed frames; wraps from FFFF to 0000.
- overrun  output  1  sticky: a `pulse` rising edge arrived after 8 bits were sent.
- underrun  output  1  sticky: a new latch arrived after 1 to 7 shifts.

Behaviour:
- Reset values: `sr`=8'hFF (so `data_out`=1), state=IDLE, count=0, `frame_strobe`=0, `frame_count`=0, `overrun`=0, `underrun`=0.
- Reset is checked ahead of every other condition; a reset mid-frame abandons the frame.
- Input path, per input:
  - SYNC_STAGES flip-flops feed a filter counter.
  - The filtered level `x_f` changes only after FILTER consecutive samples differ from it.
  - `x_rise` is a one-cycle pulse on a 0->1 change of `x_f`; `x_fall` likewise on 1->0.
- Latency: a clean input edge reaches `data_out` after SYNC_STAGES+FILTER+1 clk cycles, which is 5 with defaults. The host pulse half-period must exceed this latency.
- States:
  - IDLE: `sr` holds its value. On `latch_rise` go to LOAD.
  - LOAD: every cycle `sr <= ~buttons` and count <= 0, so `data_out` = ~A. On `latch_fall` go to SHIFT; `sr` keeps the last loaded value. `pulse` edges are ignored here (parallel mode).
  - SHIFT: on `pulse_rise`, `sr <= {1'b1, sr[7:1]}` and count <= count+1.
    - When the shift makes count reach 8, go to DONE in the same cycle.
    - In that cycle assert `frame_strobe` for one cycle and increment `frame_count`.
  - DONE: `data_out`=1. Each `pulse_rise` sets `overrun` and shifts in another 1.
- Any state except LOAD: `latch_rise` goes to LOAD. If this happens in SHIFT with count 1..7, set `underrun`. A latch with count 0 is a clean re-latch and sets no flag.
- `latch_rise` and `pulse_rise` in the same cycle: latch wins and the pulse is ignored.
- `pulse_rise` in IDLE: ignored, no flag.
- `clear_err` in the same cycle as a new error: the error flag is set (set wins).
- `count` is 4 bits and saturates at 8.

Decomposition:
- Package `n8_pkg` holds:
  - `NUM_BUTTONS`=8;
  - localparams BTN_A..BTN_RIGHT, indices 0..7;
  - enum `n8_resp_state_t` {IDLE, LOAD, SHIFT, DONE}.
- Sub-module `n8_input_filter` (synchronizer + filter + rise/fall detect), parameterized by SYNC_STAGES and FILTER. It is instantiated once for `latch` and once for `pulse`.

Test Plan:
- Reset held 3 cycles, then released with `latch`=`pulse`=0 -> `data_out`=1, `frame_count`=0, both flags 0, state IDLE.
- `buttons`=8'b0000_0101 (A, select); latch high 12 cycles then low; then 8 pulses, each 10 cycles high / 10 low:
  - after the latch, `data_out`=0 (A pressed);
  - the 8 bits sampled before each pulse read 0,1,0,1,1,1,1,1;
  - `frame_strobe` fires once, 5 cycles after the 8th pulse rises;
  - `frame_count`=1, after which `data_out`=1.
- A 9th pulse after a complete frame -> `overrun`=1, `data_out` stays 1; `clear_err` -> `overrun`=0 the next cycle.
- Latch, 3 pulses, then latch again -> `underrun`=1, `frame_count` unchanged; the following full 8-pulse frame completes and increments `frame_count`.
- 1-cycle glitch on `pulse` during SHIFT with FILTER=2 -> no shift, count unchanged, `data_out` stable.
- `latch` and `pulse` rise on the same clk edge from DONE -> state LOAD, no shift, no `overrun`. Separately, `buttons` changing during LOAD: `data_out` tracks ~A until the latch falls, then freezes.
